fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder. Holds the PC and fetches each word from instruction memory over a req/ready handshake.
- Latches the word into an instruction register and presents OpCode/funct (and the other fields) to the decoder and datapath for exactly one execute cycle.
- During that execute cycle it samples the decoder's jump/Branch outputs and the ALU zero flag, then computes and commits the next PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_TIMEOUT, 16, maximum cycles waiting for imem_ready before the fetch_err pulse; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word address of the request; equals pc.
- imem_ready  input  1  memory has valid data on imem_rdata.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction register.
- OpCode  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- instr_valid  output  1  execute cycle; datapath writes are enabled only while this is high.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc+4; used as the jal link value.
- jump  input  2  from decoder: 00 sequential, 01 j, 10 jal, 11 jr.
- Branch  input  2  from decoder: 01 beq, 10 bne, 00/11 no branch.
- zero  input  1  ALU zero flag, valid during instr_valid.
- rs_data  input  32  register-file rs read value, used as the jr target.
- fetch_err  output  1  one-cycle pulse on fetch timeout.
- halted  output  1  see Optional Feature.

Behaviour:
- Reset (clk edge with rst=1) values:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, halted=0, wait counter=0.
  - State=FETCH; imem_req rises on the first cycle after reset.
- FSM states: FETCH, EXEC, plus HALT (optional feature only).
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready is sampled high.
  - On an edge with imem_ready=1: instr<=imem_rdata, move to EXEC, imem_req drops.
  - imem_ready may be high in the first FETCH cycle, giving a minimum of 2 cycles per instruction.
  - imem_ready is ignored in every state other than FETCH.
- EXEC: lasts exactly 1 cycle with instr_valid=1. On the closing edge pc<=next_pc and the state returns to FETCH.
- next_pc, combinational from instr, pc, rs_data and the control inputs; jump has priority over Branch:
  - jump=01 or 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jump=11: {rs_data[31:2], 2'b00}; the misaligned low bits are silently cleared.
  - Branch=01 and zero=1, or Branch=10 and zero=0: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Otherwise: pc_plus4.
- Arithmetic is 32-bit modulo 2^32; pc wraps from 32'hFFFF_FFFC to 0 with no flag.
- pc[1:0] is always 0.
- Timeout (IMEM_TIMEOUT>0):
  - The counter increments every FETCH cycle with imem_ready=0 and clears on entering EXEC.
  - When it reaches IMEM_TIMEOUT, fetch_err pulses for 1 cycle, the counter clears and the request restarts at the same pc. imem_req stays high; pc is unchanged.
- Reset mid-fetch: the outstanding request is abandoned, and a late imem_ready in the reset cycle has no effect.
- Reset during EXEC: the pc update is suppressed and pc=RESET_PC.
- instr, OpCode and funct hold their last value outside EXEC; consumers must qualify them with instr_valid.

Optional Feature:
- Macro FETCH_UNIT_HALT_EN.
- When defined:
  - In EXEC, an instr equal to syscall (OpCode 000000, funct 001100) enters HALT instead of FETCH; pc is not updated.
  - In HALT: halted=1, imem_req=0, instr_valid=0. Only rst leaves HALT.
- When undefined:
  - syscall executes as a sequential no-op (pc<=pc_plus4).
  - halted is tied to 0 and the HALT state does not exist.

Test Plan:
- Reset, then memory returns ready the same cycle with 32'h3408_0005 (ori) -> imem_addr=32'h0000_3000; instr_valid high on cycle 2; next request at 32'h0000_3004.
- beq at 32'h3010 with imm=16'hFFFC, Branch=01, zero=1 -> next imem_addr=32'h0000_3004. Same with zero=0 -> 32'h0000_3014.
- jal at 32'h3020 with instr[25:0]=26'h0000C10 -> pc_plus4=32'h3024 during EXEC; next pc=32'h0000_3040.
- jr with rs_data=32'h0000_3103 -> next pc=32'h0000_3100.
- imem_ready held low with IMEM_TIMEOUT=16 -> fetch_err pulses after 16 waiting cycles; imem_addr unchanged; a later ready completes normally. rst asserted in the WAIT phase -> pc=32'h0000_3000 and the stale ready is ignored.
- With FETCH_UNIT_HALT_EN, fetch 32'h0000_000C -> halted=1 and imem_req=0 indefinitely, then rst -> fetch restarts at 32'h0000_3000. Without the macro -> pc advances by 4.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage; req/ready imem fetch, one-cycle execute, next-PC commit.
// Optional FETCH_UNIT_HALT_EN: syscall parks the stage in HALT until rst.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  jump,
  input  logic [1:0]  Branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic        fetch_err,
  output logic        halted
);

  localparam int unsigned CW =
    (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT + 1) : 1;

`ifdef FETCH_UNIT_HALT_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1
  } state_t;
`endif

  state_t          r_state;
  state_t          w_nstate;
  logic [31:0]     r_pc;
  logic [31:0]     r_instr;
  logic [CW-1:0]   r_wait;
  logic            r_err;
  logic            w_fetch;
  logic            w_exec;
  logic            w_timeout;
  logic            w_halt;
  logic            w_jimm;
  logic            w_jreg;
  logic            w_btake;
  logic [31:0]     w_pc4;
  logic [31:0]     w_boff;
  logic [31:0]     w_next_pc;
  logic            w_unused;

  assign w_fetch = (r_state == S_FETCH);
  assign w_exec  = (r_state == S_EXEC);
  assign w_pc4   = r_pc + 32'd4;
  assign w_boff  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_unused = ^rs_data[1:0];

`ifdef FETCH_UNIT_HALT_EN
  assign w_halt = w_exec && (r_instr[31:26] == 6'h00) &&
                  (r_instr[5:0] == 6'h0C);
  assign halted = (r_state == S_HALT);
`else
  assign w_halt = 1'b0;
  assign halted = 1'b0;
`endif

  assign w_timeout = (IMEM_TIMEOUT != 0) && w_fetch && !imem_ready &&
                     (r_wait == CW'(IMEM_TIMEOUT - 1));

  // jump outranks Branch, so branch decode is masked by jump==00
  assign w_jimm  = (jump == 2'b01) || (jump == 2'b10);
  assign w_jreg  = (jump == 2'b11);
  assign w_btake = (jump == 2'b00) &&
                   (((Branch == 2'b01) && zero) ||
                    ((Branch == 2'b10) && !zero));

  always_comb begin
    w_next_pc = w_pc4;
    unique case (1'b1)
      w_jimm:  w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
      w_jreg:  w_next_pc = {rs_data[31:2], 2'b00};
      w_btake: w_next_pc = w_pc4 + w_boff;
      default: w_next_pc = w_pc4;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_FETCH: if (imem_ready) w_nstate = S_EXEC;
`ifdef FETCH_UNIT_HALT_EN
      S_EXEC:  w_nstate = w_halt ? S_HALT : S_FETCH;
`else
      S_EXEC:  w_nstate = S_FETCH;
`endif
      default: w_nstate = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_nstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_fetch && imem_ready) r_instr <= imem_rdata;
      if ((IMEM_TIMEOUT != 0) && w_fetch && !imem_ready && !w_timeout)
        r_wait <= r_wait + CW'(1);
      else
        r_wait <= '0;
      if (w_exec && !w_halt) r_pc <= w_next_pc;
    end
  end

  assign imem_req    = w_fetch && !rst;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc4;
  assign instr       = r_instr;
  assign OpCode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign instr_valid = w_exec;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and random run
// against a next-PC reference model for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  jump;
  logic [1:0]  Branch;
  logic        zero;
  logic [31:0] rs_data;
  logic        fetch_err;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .OpCode(OpCode), .funct(funct),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .jump(jump), .Branch(Branch), .zero(zero), .rs_data(rs_data),
    .fetch_err(fetch_err), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] w;
    logic [1:0]  j;
    logic [1:0]  br;
    logic        z;
    logic [31:0] rs;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] ref_next(
    input logic [31:0] p, input logic [31:0] w, input logic [1:0] j,
    input logic [1:0] br, input logic z, input logic [31:0] rs);
    logic [31:0] seq;
    logic signed [15:0] imm;
    int off;
    seq = p + 32'd4;
    imm = w[15:0];
    off = imm;
    if (j == 2'd1 || j == 2'd2)
      return (seq & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 4;
    if (j == 2'd3)
      return rs - (rs % 4);
    if ((br == 2'd1 && z) || (br == 2'd2 && !z))
      return seq + 32'(off * 4);
    return seq;
  endfunction

  // Starts in a FETCH cycle at exp_pc; ends in the next FETCH cycle.
  task automatic run_instr(input logic [31:0] w, input logic [1:0] j,
                           input logic [1:0] br, input logic z,
                           input logic [31:0] rs, input int waitc,
                           input logic [31:0] nxt, input string tag);
    imem_ready = 1'b0;
    #1;
    chk({tag, ":req"}, 32'(imem_req), 32'd1);
    chk({tag, ":addr"}, imem_addr, exp_pc);
    for (int i = 0; i < waitc; i++) begin
      tick();
      chk({tag, ":addr_hold"}, imem_addr, exp_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_rdata = ~w;
    jump = j; Branch = br; zero = z; rs_data = rs;
    #1;
    chk({tag, ":valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ":instr"}, instr, w);
    chk({tag, ":op_fn"}, {20'd0, OpCode, funct}, {20'd0, w[31:26], w[5:0]});
    chk({tag, ":pc4"}, pc_plus4, exp_pc + 32'd4);
    chk({tag, ":req_exec"}, 32'(imem_req), 32'd0);
    tick();
    imem_ready = 1'b0;
    jump = 2'd0; Branch = 2'd0; zero = 1'b0;
    #1;
    chk({tag, ":valid_off"}, 32'(instr_valid), 32'd0);
    chk({tag, ":instr_hold"}, instr, w);
    chk({tag, ":next"}, imem_addr, nxt);
    exp_pc = nxt;
  endtask

  task automatic set_pc(input logic [31:0] t);
    run_instr(32'h0000_0008, 2'd3, 2'd0, 1'b0, t, 0, t & 32'hFFFF_FFFC,
              "setpc");
  endtask

  initial begin
    vec_t vt[10];
    int early;
    logic [31:0] w, rs, nxt;
    logic [1:0]  j, br;
    logic        z;

    vt[0] = '{32'h0000_3010, 32'h1000_FFFC, 2'd0, 2'd1, 1'b1, 32'd0, 32'h0000_3004};
    vt[1] = '{32'h0000_3010, 32'h1000_FFFC, 2'd0, 2'd1, 1'b0, 32'd0, 32'h0000_3014};
    vt[2] = '{32'h0000_3020, 32'h0C00_0C10, 2'd2, 2'd0, 1'b0, 32'd0, 32'h0000_3040};
    vt[3] = '{32'h0000_3000, 32'h0000_0008, 2'd3, 2'd0, 1'b0, 32'h0000_3103, 32'h0000_3100};
    vt[4] = '{32'h0000_3000, 32'h1400_0003, 2'd0, 2'd2, 1'b0, 32'd0, 32'h0000_3010};
    vt[5] = '{32'h0000_3000, 32'h1400_0003, 2'd0, 2'd2, 1'b1, 32'd0, 32'h0000_3004};
    vt[6] = '{32'hF000_0000, 32'h0800_0010, 2'd1, 2'd0, 1'b0, 32'd0, 32'hF000_0040};
    vt[7] = '{32'hFFFF_FFFC, 32'h3408_0005, 2'd0, 2'd0, 1'b0, 32'd0, 32'h0000_0000};
    vt[8] = '{32'h0000_3000, 32'h0800_0400, 2'd1, 2'd1, 1'b1, 32'd0, 32'h0000_1000};
    vt[9] = '{32'h0000_3000, 32'h1000_0010, 2'd0, 2'd3, 1'b1, 32'd0, 32'h0000_3004};

    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0;
    jump = 2'd0; Branch = 2'd0; zero = 1'b0; rs_data = 32'd0;
    tick();
    tick();
    chk("rst:req", 32'(imem_req), 32'd0);
    chk("rst:valid", 32'(instr_valid), 32'd0);
    chk("rst:err", 32'(fetch_err), 32'd0);
    chk("rst:halted", 32'(halted), 32'd0);
    chk("rst:pc", pc, 32'h0000_3000);
    chk("rst:instr", instr, 32'd0);
    rst = 1'b0;
    exp_pc = 32'h0000_3000;

    run_instr(32'h3408_0005, 2'd0, 2'd0, 1'b0, 32'd0, 0, 32'h0000_3004,
              "first_ori");

    for (int i = 0; i < 10; i++) begin
      set_pc(vt[i].pc0);
      run_instr(vt[i].w, vt[i].j, vt[i].br, vt[i].z, vt[i].rs, i % 3,
                vt[i].exp, $sformatf("vec%0d", i));
    end

    // imem stalls past the timeout, then completes
    set_pc(32'h0000_3200);
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (fetch_err) early++;
    end
    chk("to:early", early, 0);
    tick();
    chk("to:pulse", 32'(fetch_err), 32'd1);
    chk("to:addr", imem_addr, 32'h0000_3200);
    chk("to:req", 32'(imem_req), 32'd1);
    tick();
    chk("to:pulse_end", 32'(fetch_err), 32'd0);
    chk("to:pc", pc, 32'h0000_3200);
    run_instr(32'h3408_0001, 2'd0, 2'd0, 1'b0, 32'd0, 2, 32'h0000_3204,
              "to_done");

    // reset while waiting, with a stale ready in the reset cycle
    tick(); tick();
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; imem_ready = 1'b0;
    #1;
    chk("rstw:pc", pc, 32'h0000_3000);
    chk("rstw:valid", 32'(instr_valid), 32'd0);
    chk("rstw:instr", instr, 32'd0);
    exp_pc = 32'h0000_3000;
    run_instr(32'h3408_0002, 2'd0, 2'd0, 1'b0, 32'd0, 1, 32'h0000_3004,
              "rstw_go");

    // reset during the execute cycle suppresses the pc update
    set_pc(32'h0000_3400);
    imem_ready = 1'b1; imem_rdata = 32'h0800_0100;
    tick();
    imem_ready = 1'b0; jump = 2'd1; rst = 1'b1;
    tick();
    rst = 1'b0; jump = 2'd0;
    #1;
    chk("rste:pc", pc, 32'h0000_3000);
    chk("rste:valid", 32'(instr_valid), 32'd0);
    exp_pc = 32'h0000_3000;

`ifdef FETCH_UNIT_HALT_EN
    imem_ready = 1'b1; imem_rdata = 32'h0000_000C;
    tick();
    imem_ready = 1'b0;
    tick();
    chk("halt:halted", 32'(halted), 32'd1);
    chk("halt:req", 32'(imem_req), 32'd0);
    chk("halt:pc", pc, 32'h0000_3000);
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      tick();
    end
    imem_ready = 1'b0;
    chk("halt:stay", {29'd0, halted, imem_req, instr_valid}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("halt:rst", 32'(halted), 32'd0);
    exp_pc = 32'h0000_3000;
    run_instr(32'h3408_0003, 2'd0, 2'd0, 1'b0, 32'd0, 0, 32'h0000_3004,
              "halt_restart");
`else
    run_instr(32'h0000_000C, 2'd0, 2'd0, 1'b0, 32'd0, 0, 32'h0000_3004,
              "syscall_nop");
    chk("nohalt", 32'(halted), 32'd0);
`endif

    for (int k = 0; k < 200; k++) begin
      w  = $urandom;
      if (w[31:26] == 6'd0 && w[5:0] == 6'h0C) w[0] = 1'b1;
      j  = 2'($urandom_range(0, 3));
      br = 2'($urandom_range(0, 3));
      z  = 1'($urandom_range(0, 1));
      rs = $urandom;
      nxt = ref_next(exp_pc, w, j, br, z, rs);
      run_instr(w, j, br, z, rs, $urandom_range(0, 4), nxt,
                $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
